timer_sequencer: RTL

Control sequencer for the countdown-timer datapath. Merges debounced button pulses and UART command bytes into single-cycle `inc`/`dec`/`clear` pulses, a level `run_stop`, and an edit-field select. Runs the STOP/RUN/ALARM state machine, including the expiry alarm blink. Returns single-byte status replies to the UART transmitter over a `tx_empty`/`tx_start` handshake. Sits between the button debouncers / UART RX and the timer datapath / UART TX.

---
 rtl/timer_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/timer_sequencer.sv
// timer_sequencer
// Control sequencer for the countdown-timer datapath.
//   - Merges debounced button pulses and UART command bytes into single-cycle
//     inc/dec/clear pulses, a run_stop level and an edit-field select.
//   - Runs the STOP/RUN/ALARM state machine, including the expiry alarm blink.
//   - Answers 'S' status requests with one byte over a tx_empty/tx_start
//     handshake ('T' = STOP, 'R' = RUN, 'A' = ALARM).
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   btn_L/btn_R/btn_U/btn_D   : 1-cycle button pulses (clear/run-stop/inc/dec)
//   rx_valid, rx_data[7:0]    : UART command byte strobe and data
//   time_zero                 : datapath reports all-zero time
//   tx_empty                  : UART TX ready for a byte
//   inc, dec, clear           : 1-cycle datapath command pulses
//   run_stop                  : datapath counts while high
//   field_sel[1:0]            : edit target (00 sec, 01 min, 10 hour)
//   alarm_led                 : blinking expiry indicator
//   tx_start, tx_data[7:0]    : status byte send strobe and held byte
module timer_sequencer #(
  parameter int unsigned BLINK_CYC     = 50_000_000,
  parameter int unsigned ALARM_TOGGLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_L,
  input  logic       btn_R,
  input  logic       btn_U,
  input  logic       btn_D,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       time_zero,
  input  logic       tx_empty,
  output logic       inc,
  output logic       dec,
  output logic       clear,
  output logic       run_stop,
  output logic [1:0] field_sel,
  output logic       alarm_led,
  output logic       tx_start,
  output logic [7:0] tx_data
);

  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int TW = (ALARM_TOGGLES > 1) ? $clog2(ALARM_TOGGLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYC - 1);
  localparam logic [TW-1:0] TOGGLE_LAST = TW'(ALARM_TOGGLES - 1);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            inc_reg, inc_next;
  logic            dec_reg, dec_next;
  logic            clear_reg, clear_next;
  logic            run_stop_reg, run_stop_next;
  logic [1:0]      field_reg, field_next;
  logic            led_reg, led_next;
  logic [BW-1:0]   blink_reg, blink_next;
  logic [TW-1:0]   tog_reg, tog_next;
  logic            tx_pend_reg, tx_pend_next;
  logic            tx_start_reg, tx_start_next;
  logic [7:0]      tx_data_reg, tx_data_next;

  // Command merge: a button and its matching UART byte form one event.
  logic uart_c, uart_r, uart_u, uart_d, uart_f, uart_s;
  logic cmd_clear, cmd_rs, cmd_inc, cmd_dec, cmd_field, any_cmd;
  logic send;

  assign uart_c = rx_valid && (rx_data == 8'h43);
  assign uart_r = rx_valid && (rx_data == 8'h52);
  assign uart_u = rx_valid && (rx_data == 8'h55);
  assign uart_d = rx_valid && (rx_data == 8'h44);
  assign uart_f = rx_valid && (rx_data == 8'h46);
  assign uart_s = rx_valid && (rx_data == 8'h53);

  assign cmd_clear = btn_L | uart_c;
  assign cmd_rs    = btn_R | uart_r;
  assign cmd_inc   = btn_U | uart_u;
  assign cmd_dec   = btn_D | uart_d;
  assign cmd_field = uart_f;
  assign any_cmd   = cmd_clear | cmd_rs | cmd_inc | cmd_dec | cmd_field;

  // Main state machine and datapath command outputs.
  always_comb begin
    state_next = state_reg;
    inc_next   = 1'b0;
    dec_next   = 1'b0;
    clear_next = 1'b0;
    field_next = field_reg;
    led_next   = 1'b0;
    blink_next = blink_reg;
    tog_next   = tog_reg;

    unique case (state_reg)
      STOP: begin
        // Priority chain: a run/stop refused because time is zero still
        // consumes the cycle, so lower-priority commands do not act.
        if (cmd_clear) begin
          clear_next = 1'b1;
        end else if (cmd_rs) begin
          if (!time_zero) state_next = RUN;
        end else if (cmd_inc) begin
          inc_next = 1'b1;
        end else if (cmd_dec) begin
          dec_next = 1'b1;
        end else if (cmd_field) begin
          field_next = (field_reg == 2'b10) ? 2'b00 : field_reg + 2'b01;
        end
      end

      RUN: begin
        if (cmd_clear) begin
          clear_next = 1'b1;
          state_next = STOP;
        end else if (cmd_rs) begin
          state_next = STOP;
        end else if (time_zero) begin
          state_next = ALARM;
          led_next   = 1'b1;
          blink_next = '0;
          tog_next   = '0;
        end
      end

      ALARM: begin
        led_next = led_reg;
        if (any_cmd) begin
          // Acknowledge only: the command itself is swallowed.
          state_next = STOP;
          led_next   = 1'b0;
        end else if (blink_reg == BLINK_LAST) begin
          blink_next = '0;
          if (tog_reg == TOGGLE_LAST) begin
            state_next = STOP;
            led_next   = 1'b0;
          end else begin
            tog_next = tog_reg + 1'b1;
            led_next = ~led_reg;
          end
        end else begin
          blink_next = blink_reg + 1'b1;
        end
      end

      default: begin
        state_next = STOP;
      end
    endcase

    run_stop_next = (state_next == RUN);
  end

  // Status reply: a request arriving on the sending edge stays pending for
  // the next send; one arriving while already pending is absorbed.
  always_comb begin
    send          = tx_pend_reg && tx_empty;
    tx_start_next = send;
    tx_pend_next  = uart_s | (tx_pend_reg & ~send);
    tx_data_next  = tx_data_reg;
    if (send) begin
      unique case (state_reg)
        RUN:     tx_data_next = 8'h52;
        ALARM:   tx_data_next = 8'h41;
        default: tx_data_next = 8'h54;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= STOP;
      inc_reg      <= 1'b0;
      dec_reg      <= 1'b0;
      clear_reg    <= 1'b0;
      run_stop_reg <= 1'b0;
      field_reg    <= 2'b01;
      led_reg      <= 1'b0;
      blink_reg    <= '0;
      tog_reg      <= '0;
      tx_pend_reg  <= 1'b0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      state_reg    <= state_next;
      inc_reg      <= inc_next;
      dec_reg      <= dec_next;
      clear_reg    <= clear_next;
      run_stop_reg <= run_stop_next;
      field_reg    <= field_next;
      led_reg      <= led_next;
      blink_reg    <= blink_next;
      tog_reg      <= tog_next;
      tx_pend_reg  <= tx_pend_next;
      tx_start_reg <= tx_start_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  assign inc       = inc_reg;
  assign dec       = dec_reg;
  assign clear     = clear_reg;
  assign run_stop  = run_stop_reg;
  assign field_sel = field_reg;
  assign alarm_led = led_reg;
  assign tx_start  = tx_start_reg;
  assign tx_data   = tx_data_reg;

endmodule
